jtframe_prog_loader: RTL and testbench
======================================

Name: jtframe_prog_loader

Overview:
Downstream consumer of the MiSTer download stream (ioctl_rom_wr/ioctl_addr/ioctl_data). It converts byte-wide ROM download writes into SDRAM programming requests (prog_addr/prog_data/prog_mask/prog_bank/prog_we) for the board SDRAM controller. A small FIFO absorbs bursts while the SDRAM controller is busy. The block drives dwnld_busy, which holds the game in reset until the last byte is committed plus a settle time.

Parameters:
HEADER, 0, bytes at the start of the stream that are skipped (MRA header); the remaining addresses are rebased to 0.
BA1_START, 25'h10_0000, first rebased byte address mapped to SDRAM bank 1.
BA2_START, 25'h20_0000, first rebased byte address mapped to bank 2.
BA3_START, 25'h30_0000, first rebased byte address mapped to bank 3.
ROM_END, 25'h40_0000, rebased byte addresses >= this are discarded.
FIFO_AW, 2, FIFO address width; depth is 2**FIFO_AW entries.
POST_CYCLES, 16, clk_rom cycles dwnld_busy stays high after the final write is acknowledged.

Ports:
clk_rom in 1: ROM/download clock; all logic runs on this clock.
rst in 1: reset, asynchronous, active-high.
downloading in 1: ROM download in progress (index 0).
ioctl_rom_wr in 1: one-cycle byte write strobe.
ioctl_addr in 25: byte address of the write.
ioctl_data in 8: byte data.
prog_rdy in 1: SDRAM controller acknowledge for the current prog_we request.
prog_addr out 22: 16-bit word address within the bank.
prog_data out 8: byte to write; the controller replicates it on both lanes.
prog_mask out 2: active-low byte enables; bit 0 is the low byte.
prog_bank out 2: SDRAM bank.
prog_we out 1: write request level.
dwnld_busy out 1: download or commit still in progress.
overflow out 1: sticky flag, set when a byte was dropped because the FIFO was full.

Behaviour:
- Reset values: prog_addr=0, prog_data=0, prog_mask=2'b11, prog_bank=0, prog_we=0, dwnld_busy=0, overflow=0. The FIFO is emptied and the state machine goes to IDLE. Asserting rst mid-transfer abandons the pending request immediately.
- Accept: on a cycle where ioctl_rom_wr=1 and downloading=1:
  - Compute r = ioctl_addr - HEADER.
  - If ioctl_addr < HEADER or r >= ROM_END, drop the byte silently.
  - Otherwise push {bank, offset, data}:
    - bank = 3 if r>=BA3_START, else 2 if r>=BA2_START, else 1 if r>=BA1_START, else 0.
    - offset = r minus that bank's start (start of bank 0 is 0).
  - The mapping is registered at push time. Pushes with downloading=0 are ignored.
- FIFO:
  - A push into a full FIFO is discarded and sets overflow. overflow clears only on a rising edge of downloading or on rst.
  - A push and a pop in the same cycle are both honoured, including when the FIFO is full.
- Output state machine, IDLE / REQ / GAP:
  - IDLE -> REQ when the FIFO is non-empty. On that edge load prog_addr=offset[22:1], prog_data=data, prog_bank=bank, and prog_mask: 2'b10 if offset[0]=0, 2'b01 if offset[0]=1. prog_we=1 from the next cycle.
  - REQ: prog_we and all prog_* outputs are held stable until prog_rdy=1 is sampled. On that cycle pop the FIFO, go to GAP, and set prog_we=0 the following cycle.
  - GAP: one cycle with prog_we=0, then IDLE. A new request can therefore start no sooner than 2 cycles after the previous acknowledge. prog_mask returns to 2'b11 in GAP.
  - prog_rdy outside REQ is ignored.
- dwnld_busy:
  - Goes to 1 the cycle after downloading rises.
  - After downloading falls, it stays 1 until the FIFO is empty and the state is IDLE. It then counts POST_CYCLES cycles and drops to 0.
  - If downloading rises again during the count, the count is cancelled and dwnld_busy stays 1.
- Wrap/limits:
  - offset is 23 bits. Bank ranges larger than 8 MB are not supported; the parameters must keep every bank range within 8 MB.
  - prog_addr never wraps within a bank.

Decomposition:
- Shared package jtframe_prog_pkg:
  - typedef prog_entry_t {bank[1:0], offset[22:0], data[7:0]}.
  - State enum {IDLE, REQ, GAP}.
  - Constant MASK_NONE=2'b11.
- One sub-module, jtframe_prog_fifo: synchronous FIFO with parameter FIFO_AW, push/pop/full/empty, simultaneous push/pop. It is reusable for other download paths.

Test Plan:
1. HEADER=0, prog_rdy tied high, write 0x12 @0, 0x34 @1 with 100 cycles between bytes -> word 0: first request mask 2'b10 data 0x12, second request mask 2'b01 data 0x34, prog_bank=0.
2. Write @25'h10_0003 with data 0xAA -> prog_bank=1, prog_addr=1, mask 2'b01; @25'h3F_FFFE -> bank 3, prog_addr=22'h7_FFFF, mask 2'b10; @25'h40_0000 -> no prog_we.
3. HEADER=64: writes @0..63 -> no requests; write @64 data 0x5A -> bank 0, prog_addr=0, mask 2'b10, data 0x5A.
4. prog_rdy held low, 5 back-to-back strobes (FIFO_AW=2) -> overflow=1, exactly 4 requests issued after prog_rdy released, with prog_we low for at least 1 cycle between them.
5. downloading falls with 3 entries queued and prog_rdy delayed 10 cycles each -> dwnld_busy falls exactly POST_CYCLES=16 cycles after the final GAP->IDLE; no earlier.
6. Assert rst while prog_we=1 -> prog_we=0 and dwnld_busy=0 asynchronously; after release with downloading=0, no request is issued.

Source files
------------

// File: rtl/jtframe_prog_pkg.sv
// Shared types for the ROM download to SDRAM programming path.
package jtframe_prog_pkg;

  typedef struct packed {
    logic [1:0]  bank;
    logic [22:0] offset;
    logic [7:0]  data;
  } prog_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [1:0] MASK_NONE = 2'b11;

  // Active-low lane enable for a byte offset: even bytes go to the low lane.
  function automatic logic [1:0] lane_mask(input logic odd);
    return odd ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/jtframe_prog_fifo.sv
// Small synchronous FIFO; a push and a pop in the same cycle are both taken,
// even when full, so a draining consumer never causes a drop.
module jtframe_prog_fifo #(
  parameter int FIFO_AW = 2,
  parameter int W       = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         drop_o
);

  localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};

  logic [W-1:0]       mem_q [2**FIFO_AW];
  logic [FIFO_AW-1:0] wr_q, wr_d;
  logic [FIFO_AW-1:0] rd_q, rd_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic               push_ok, pop_ok;

  assign full_o  = (cnt_q == DEPTH);
  assign empty_o = (cnt_q == '0);
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign drop_o  = push_i & ~push_ok;
  assign dout_o  = mem_q[rd_q];

  always_comb begin
    wr_d  = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d  = pop_ok  ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q;
    if (push_ok && !pop_ok) cnt_d = cnt_q + 1'b1;
    if (!push_ok && pop_ok) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/jtframe_prog_loader.sv
// Turns byte-wide ROM download writes into banked SDRAM programming requests
// and keeps dwnld_busy high until everything is committed plus a settle time.
module jtframe_prog_loader
  import jtframe_prog_pkg::*;
#(
  parameter logic [24:0] HEADER      = 25'd0,
  parameter logic [24:0] BA1_START   = 25'h10_0000,
  parameter logic [24:0] BA2_START   = 25'h20_0000,
  parameter logic [24:0] BA3_START   = 25'h30_0000,
  parameter logic [24:0] ROM_END     = 25'h40_0000,
  parameter int          FIFO_AW     = 2,
  parameter int          POST_CYCLES = 16
) (
  input  logic        clk_rom,
  input  logic        rst,
  input  logic        downloading,
  input  logic        ioctl_rom_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        prog_rdy,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic [1:0]  prog_bank,
  output logic        prog_we,
  output logic        dwnld_busy,
  output logic        overflow,
  output state_t      prog_st
);

  localparam logic [22:0] BA1_OFS = BA1_START[22:0];
  localparam logic [22:0] BA2_OFS = BA2_START[22:0];
  localparam logic [22:0] BA3_OFS = BA3_START[22:0];
  localparam int          CW      = $clog2(POST_CYCLES + 1);
  localparam logic [CW-1:0] POST_LAST = CW'(POST_CYCLES - 1);

  logic [25:0]  rel_w;
  logic [24:0]  r_w;
  logic         in_range_w, push_w, pop_w;
  logic [1:0]   bank_w;
  logic [22:0]  base_w;
  prog_entry_t  push_entry, head;
  logic         fifo_empty, fifo_full, fifo_drop;

  state_t       state_q;
  logic [21:0]  addr_q;
  logic [7:0]   data_q;
  logic [1:0]   mask_q, bank_q;
  logic         we_q, busy_q, ovf_q, dl_q;
  logic [CW-1:0] post_cnt_q;

  // Bit 25 of the widened difference is the borrow: address inside the header.
  assign rel_w      = {1'b0, ioctl_addr} - {1'b0, HEADER};
  assign r_w        = rel_w[24:0];
  assign in_range_w = !rel_w[25] && (r_w < ROM_END);
  assign push_w     = ioctl_rom_wr && downloading && in_range_w;

  always_comb begin
    bank_w = 2'd0;
    base_w = 23'd0;
    if (r_w >= BA3_START) begin
      bank_w = 2'd3;
      base_w = BA3_OFS;
    end else if (r_w >= BA2_START) begin
      bank_w = 2'd2;
      base_w = BA2_OFS;
    end else if (r_w >= BA1_START) begin
      bank_w = 2'd1;
      base_w = BA1_OFS;
    end
    push_entry.bank   = bank_w;
    push_entry.offset = r_w[22:0] - base_w;
    push_entry.data   = ioctl_data;
  end

  jtframe_prog_fifo #(
    .FIFO_AW (FIFO_AW),
    .W       ($bits(prog_entry_t))
  ) u_fifo (
    .clk_i   (clk_rom),
    .rst_i   (rst),
    .push_i  (push_w),
    .din_i   (push_entry),
    .pop_i   (pop_w),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

  // prog_we is a valid level: once raised, all prog_* hold until the cycle
  // prog_rdy is sampled high with it; that cycle is the transfer and the pop.
  assign pop_w = (state_q == REQ) && prog_rdy;

  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= MASK_NONE;
      bank_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (!fifo_empty) begin
          addr_q  <= head.offset[22:1];
          data_q  <= head.data;
          bank_q  <= head.bank;
          mask_q  <= lane_mask(head.offset[0]);
          we_q    <= 1'b1;
          state_q <= REQ;
        end
        REQ: if (prog_rdy) begin
          we_q    <= 1'b0;
          mask_q  <= MASK_NONE;
          state_q <= GAP;
        end
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Settle counter only runs once the download has ended and the path is drained.
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      dl_q       <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      post_cnt_q <= '0;
    end else begin
      dl_q <= downloading;
      if (downloading) begin
        busy_q     <= 1'b1;
        post_cnt_q <= '0;
      end else if (busy_q && fifo_empty && state_q == IDLE) begin
        if (post_cnt_q == POST_LAST) busy_q <= 1'b0;
        else post_cnt_q <= post_cnt_q + 1'b1;
      end else begin
        post_cnt_q <= '0;
      end
      if (downloading && !dl_q) ovf_q <= 1'b0;
      if (fifo_drop) ovf_q <= 1'b1;
    end
  end

  assign prog_addr  = addr_q;
  assign prog_data  = data_q;
  assign prog_mask  = mask_q;
  assign prog_bank  = bank_q;
  assign prog_we    = we_q;
  assign dwnld_busy = busy_q;
  assign overflow   = ovf_q;
  assign prog_st    = state_q;

endmodule

// File: tb/tb_jtframe_prog_loader.sv
// Directed bench for jtframe_prog_loader: vector table plus multi-cycle sequences.
module tb_jtframe_prog_loader;
  import jtframe_prog_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        dl = 1'b0, dl_h = 1'b0, wr = 1'b0, rdy = 1'b0, sel_h = 1'b0;
  logic [24:0] addr = '0;
  logic [7:0]  data = '0;

  logic [21:0] p_addr, p_addr_h;
  logic [7:0]  p_data, p_data_h;
  logic [1:0]  p_mask, p_mask_h, p_bank, p_bank_h;
  logic        p_we, p_we_h, busy, busy_h, ovf, ovf_h;
  state_t      st, st_h;

  jtframe_prog_loader dut (
    .clk_rom(clk), .rst(rst), .downloading(dl), .ioctl_rom_wr(wr),
    .ioctl_addr(addr), .ioctl_data(data), .prog_rdy(rdy),
    .prog_addr(p_addr), .prog_data(p_data), .prog_mask(p_mask), .prog_bank(p_bank),
    .prog_we(p_we), .dwnld_busy(busy), .overflow(ovf), .prog_st(st)
  );

  jtframe_prog_loader #(.HEADER(25'd64)) dut_h (
    .clk_rom(clk), .rst(rst), .downloading(dl_h), .ioctl_rom_wr(wr),
    .ioctl_addr(addr), .ioctl_data(data), .prog_rdy(rdy),
    .prog_addr(p_addr_h), .prog_data(p_data_h), .prog_mask(p_mask_h), .prog_bank(p_bank_h),
    .prog_we(p_we_h), .dwnld_busy(busy_h), .overflow(ovf_h), .prog_st(st_h)
  );

  // scoreboard: {bank, word addr, mask, data} of each expected handshake
  logic [33:0] exp_q[$];
  logic [33:0] m_req, e_req;
  logic        m_we;
  logic [1:0]  m_mask;
  int          checks = 0, failures = 0, acks = 0;
  logic        ack_prev = 1'b0;

  assign m_we   = sel_h ? p_we_h : p_we;
  assign m_mask = sel_h ? p_mask_h : p_mask;
  assign m_req  = sel_h ? {p_bank_h, p_addr_h, p_mask_h, p_data_h}
                        : {p_bank, p_addr, p_mask, p_data};

  always @(negedge clk) begin
    if (rst) begin
      ack_prev = 1'b0;
    end else begin
      if (ack_prev) begin
        checks++;
        if (m_we !== 1'b0 || m_mask !== MASK_NONE) begin
          failures++;
          $display("FAIL gap_after_ack: we=%b mask=%b required we=0 mask=11", m_we, m_mask);
        end
      end
      ack_prev = m_we && rdy;
      if (m_we && rdy) begin
        acks++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_req: got %h required none", m_req);
        end else begin
          e_req = exp_q.pop_front();
          if (m_req !== e_req) begin
            failures++;
            $display("FAIL req: got %h required %h", m_req, e_req);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  // driver tasks
  task automatic write_byte(input logic [24:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    addr = a; data = d; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic wait_we(input string name);
    int n = 0;
    while (!p_we && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!p_we) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: prog_we=0 required 1", name);
    end
  endtask

  typedef struct {
    logic        hdr;
    logic [24:0] a;
    logic [7:0]  d;
    logic        exp;
    logic [1:0]  bank;
    logic [21:0] paddr;
    logic [1:0]  mask;
  } vec_t;

  vec_t vecs[16];
  int   a0, n;

  initial begin
    vecs[0]  = '{1'b0, 25'h000_0000, 8'h12, 1'b1, 2'd0, 22'h00_0000, 2'b10};
    vecs[1]  = '{1'b0, 25'h000_0001, 8'h34, 1'b1, 2'd0, 22'h00_0000, 2'b01};
    vecs[2]  = '{1'b0, 25'h010_0003, 8'hAA, 1'b1, 2'd1, 22'h00_0001, 2'b01};
    vecs[3]  = '{1'b0, 25'h03F_FFFE, 8'h77, 1'b1, 2'd3, 22'h07_FFFF, 2'b10};
    vecs[4]  = '{1'b0, 25'h040_0000, 8'h99, 1'b0, 2'd0, 22'h00_0000, 2'b11};
    vecs[5]  = '{1'b0, 25'h01F_FFFF, 8'h5C, 1'b1, 2'd1, 22'h07_FFFF, 2'b01};
    vecs[6]  = '{1'b0, 25'h020_0000, 8'hC3, 1'b1, 2'd2, 22'h00_0000, 2'b10};
    vecs[7]  = '{1'b0, 25'h00F_FFFF, 8'h3E, 1'b1, 2'd0, 22'h07_FFFF, 2'b01};
    vecs[8]  = '{1'b0, 25'h1FF_FFFF, 8'h44, 1'b0, 2'd0, 22'h00_0000, 2'b11};
    vecs[9]  = '{1'b1, 25'h000_0000, 8'h01, 1'b0, 2'd0, 22'h00_0000, 2'b11};
    vecs[10] = '{1'b1, 25'h000_003F, 8'h02, 1'b0, 2'd0, 22'h00_0000, 2'b11};
    vecs[11] = '{1'b1, 25'h000_0040, 8'h5A, 1'b1, 2'd0, 22'h00_0000, 2'b10};
    vecs[12] = '{1'b1, 25'h000_0041, 8'h11, 1'b1, 2'd0, 22'h00_0000, 2'b01};
    vecs[13] = '{1'b1, 25'h010_0040, 8'h22, 1'b1, 2'd1, 22'h00_0000, 2'b10};
    vecs[14] = '{1'b1, 25'h040_003F, 8'h66, 1'b1, 2'd3, 22'h07_FFFF, 2'b01};
    vecs[15] = '{1'b1, 25'h040_0040, 8'h67, 1'b0, 2'd0, 22'h00_0000, 2'b11};

    // reset values, applied asynchronously before any clock edge
    #2 rst = 1'b1;
    #1;
    check("rst_addr", p_addr, 0);
    check("rst_data", p_data, 0);
    check("rst_mask", p_mask, 2'b11);
    check("rst_bank", p_bank, 0);
    check("rst_we", p_we, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // dwnld_busy rises one cycle after downloading
    @(posedge clk); #1 dl = 1'b1; rdy = 1'b1;
    @(negedge clk); check("busy_before_edge", busy, 0);
    @(negedge clk); check("busy_rise", busy, 1);

    // vector table, prog_rdy tied high
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      sel_h = vecs[i].hdr;
      dl    = !vecs[i].hdr;
      dl_h  = vecs[i].hdr;
      if (vecs[i].exp)
        exp_q.push_back({vecs[i].bank, vecs[i].paddr, vecs[i].mask, vecs[i].d});
      a0 = acks;
      write_byte(vecs[i].a, vecs[i].d);
      repeat (100) @(negedge clk);
      check($sformatf("vec%0d_reqs", i), acks - a0, {63'd0, vecs[i].exp});
    end

    // whole header range on the HEADER=64 instance produces nothing
    a0 = acks;
    for (int j = 0; j < 64; j++) write_byte(25'(j), 8'(j));
    repeat (20) @(negedge clk);
    check("header_skip", acks - a0, 0);

    // overflow: 5 back-to-back strobes with the controller stalled
    @(posedge clk); #1;
    sel_h = 1'b0; dl_h = 1'b0; dl = 1'b1; rdy = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      addr = 25'h200 + 25'(i); data = 8'hB0 + 8'(i); wr = 1'b1;
      if (i < 4)
        exp_q.push_back({2'd0, 22'h100 + 22'(i / 2), (i % 2 == 1) ? 2'b01 : 2'b10, 8'hB0 + 8'(i)});
      @(posedge clk); #1;
    end
    wr = 1'b0;
    repeat (10) @(negedge clk);
    check("ovf_set", ovf, 1);
    check("stall_we", p_we, 1);
    check("stall_data", p_data, 8'hB0);
    check("stall_mask", p_mask, 2'b10);
    @(posedge clk); #1 dl = 1'b0;
    @(negedge clk); check("ovf_sticky", ovf, 1);
    a0 = acks;
    @(posedge clk); #1 rdy = 1'b1;
    repeat (100) @(negedge clk);
    check("ovf_drain_reqs", acks - a0, 4);
    @(posedge clk); #1 dl = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); check("ovf_clear", ovf, 0);

    // settle time after the last commit
    rdy = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      addr = 25'h300 + 25'(i); data = 8'hC0 + 8'(i); wr = 1'b1;
      exp_q.push_back({2'd0, 22'h180 + 22'(i / 2), (i % 2 == 1) ? 2'b01 : 2'b10, 8'hC0 + 8'(i)});
      @(posedge clk); #1;
    end
    wr = 1'b0;
    dl = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_we($sformatf("post_req%0d", k));
      repeat (10) @(posedge clk);
      #1 rdy = 1'b1;
      @(posedge clk); #1 rdy = 1'b0;
    end
    check("post_state_gap", st, GAP);
    check("post_busy_gap", busy, 1);
    @(posedge clk);
    n = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    check("post_cycles", n, 16);

    // reset while a request is outstanding
    @(posedge clk); #1 dl = 1'b1;
    write_byte(25'h400, 8'hEE);
    wait_we("rst_req");
    #2 rst = 1'b1;
    #1;
    check("midrst_we", p_we, 0);
    check("midrst_busy", busy, 0);
    check("midrst_mask", p_mask, 2'b11);
    @(posedge clk); #1 dl = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    write_byte(25'h402, 8'h0F);
    n = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (p_we) n++;
    end
    check("after_rst_no_req", n, 0);
    check("after_rst_busy", busy, 0);

    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
